// File: rtl/ncl_word_sync_receiver.sv
// ncl_word_sync_receiver: clocked consumer for a dual-rail NCL word.
// It samples the word and drives the completion/acknowledge rail back to the ring.
// It delivers each decoded word over a valid/ready interface.
//
// Ports:
//   clk          sampling clock
//   init_n       asynchronous reset, active low
//   ncl_rail0    FALSE rail of each bit, asynchronous to clk
//   ncl_rail1    TRUE rail of each bit, asynchronous to clk
//   ncl_ack      completion to the ring: 1 = DATA accepted (send NULL), 0 = send DATA
//   word_out     decoded binary word (bit i = rail1[i]), stable while word_valid
//   word_valid   word_out holds an undelivered word
//   word_ready   consumer accepts the word when word_valid & word_ready
//   err_illegal  sticky: some bit had both rails high in a stable sample
//   seq_err      (SEQ_CHECK_EN only) sticky: a capture was not previous word + 1
//
// Optional feature: define SEQ_CHECK_EN to add the sequence checker and seq_err.
module ncl_word_sync_receiver #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic [WIDTH-1:0] ncl_rail0,
  input  logic [WIDTH-1:0] ncl_rail1,
  output logic             ncl_ack,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
`ifdef SEQ_CHECK_EN
  output logic             seq_err,
`endif
  output logic             err_illegal
);

  typedef enum logic {WAIT_DATA, WAIT_NULL} state_t;

  state_t                            r_state;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync0, r_sync1;
  logic [WIDTH-1:0]                  r_p0, r_p1, r_word;
  logic                              r_ack, r_valid, r_err;
  logic [WIDTH-1:0]                  w_s0, w_s1;
  logic                              w_stable, w_data, w_null, w_illeg, w_capture, w_release;

  assign w_s0 = r_sync0[SYNC_STAGES-1];
  assign w_s1 = r_sync1[SYNC_STAGES-1];
  // Two equal consecutive samples absorb skew between rails and between bits.
  assign w_stable  = (w_s0 == r_p0) && (w_s1 == r_p1);
  assign w_data    = &(w_s0 ^ w_s1);
  assign w_null    = ~|(w_s0 | w_s1);
  assign w_illeg   = |(w_s0 & w_s1);
  assign w_capture = (r_state == WAIT_DATA) && w_stable && w_data && !r_valid;
  // The ring is only released once the held word has gone or is leaving this cycle.
  assign w_release = (r_state == WAIT_NULL) && w_stable && w_null && (!r_valid || word_ready);

  assign ncl_ack     = r_ack;
  assign word_out    = r_word;
  assign word_valid  = r_valid;
  assign err_illegal = r_err;

  always_ff @(posedge clk or negedge init_n)
    if (!init_n) begin
      r_sync0 <= '0;
      r_sync1 <= '0;
      r_p0    <= '0;
      r_p1    <= '0;
      r_word  <= '0;
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_state <= WAIT_DATA;
    end else begin
      r_sync0 <= {r_sync0[SYNC_STAGES-2:0], ncl_rail0};
      r_sync1 <= {r_sync1[SYNC_STAGES-2:0], ncl_rail1};
      r_p0    <= w_s0;
      r_p1    <= w_s1;
      if (w_stable && w_illeg) r_err <= 1'b1;
      if (r_valid && word_ready) r_valid <= 1'b0;
      if (w_capture) begin
        r_word  <= w_s1;
        r_valid <= 1'b1;
        r_ack   <= 1'b1;
        r_state <= WAIT_NULL;
      end
      if (w_release) begin
        r_ack   <= 1'b0;
        r_state <= WAIT_DATA;
      end
    end

`ifdef SEQ_CHECK_EN
  logic [WIDTH-1:0] r_last;
  logic             r_have, r_seq;
  assign seq_err = r_seq;
  always_ff @(posedge clk or negedge init_n)
    if (!init_n) begin
      r_last <= '0;
      r_have <= 1'b0;
      r_seq  <= 1'b0;
    end else if (w_capture) begin
      r_last <= w_s1;
      r_have <= 1'b1;
      if (r_have && (w_s1 != r_last + WIDTH'(1))) r_seq <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_ncl_word_sync_receiver.sv
// tb_ncl_word_sync_receiver: directed self-checking bench for ncl_word_sync_receiver.
module tb_ncl_word_sync_receiver;

  logic        clk = 1'b0;
  logic        init_n;
  logic [31:0] ncl_rail0, ncl_rail1;
  logic        ncl_ack;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        err_illegal;
`ifdef SEQ_CHECK_EN
  logic        seq_err;
`endif

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_deliv = 0;
  logic [31:0] last_deliv = '0;

  ncl_word_sync_receiver #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .init_n(init_n),
    .ncl_rail0(ncl_rail0),
    .ncl_rail1(ncl_rail1),
    .ncl_ack(ncl_ack),
    .word_out(word_out),
    .word_valid(word_valid),
    .word_ready(word_ready),
`ifdef SEQ_CHECK_EN
    .seq_err(seq_err),
`endif
    .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (init_n && word_valid && word_ready) begin
      n_deliv++;
      last_deliv = word_out;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_word(input logic [31:0] v);
    ncl_rail1 = v;
    ncl_rail0 = ~v;
  endtask

  task automatic drive_null();
    ncl_rail1 = '0;
    ncl_rail0 = '0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] v);
    drive_word(v);
    cyc(5);
    drive_null();
    cyc(5);
  endtask

  initial begin
    init_n     = 1'b0;
    word_ready = 1'b0;
    ncl_rail0  = $urandom;
    ncl_rail1  = $urandom;
    cyc(3);
    chk("rst_ack", ncl_ack, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_word", word_out, 0);
    chk("rst_err", err_illegal, 0);
`ifdef SEQ_CHECK_EN
    chk("rst_seq", seq_err, 0);
`endif
    drive_null();
    cyc(2);
    init_n = 1'b1;
    cyc(5);

    // Basic cycle with latency check: capture on the 4th edge after the change.
    word_ready = 1'b1;
    drive_word(32'h5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lat_valid_early", word_valid, 0);
    chk("lat_ack_early", ncl_ack, 0);
    @(negedge clk);
    chk("lat_valid", word_valid, 1);
    chk("lat_ack", ncl_ack, 1);
    chk("lat_word", word_out, 32'h5);
    @(negedge clk);
    chk("basic_delivered", word_valid, 0);
    chk("basic_ack_hold", ncl_ack, 1);
    drive_null();
    cyc(3);
    chk("null_ack_early", ncl_ack, 1);
    cyc(1);
    chk("null_ack", ncl_ack, 0);
    chk("basic_count", n_deliv, 1);
    chk("basic_last", last_deliv, 32'h5);

    // Back-pressure: ack held high while the word is undelivered.
    word_ready = 1'b0;
    drive_word(32'h7);
    cyc(5);
    chk("bp_valid", word_valid, 1);
    chk("bp_word", word_out, 32'h7);
    drive_null();
    cyc(8);
    chk("bp_ack_held", ncl_ack, 1);
    drive_word(32'h8);
    cyc(8);
    chk("bp_no_capture", word_out, 32'h7);
    chk("bp_ack_held2", ncl_ack, 1);
    drive_null();
    cyc(6);
    word_ready = 1'b1;
    cyc(1);
    chk("bp_drain_valid", word_valid, 0);
    chk("bp_drain_ack", ncl_ack, 0);
    chk("bp_count", n_deliv, 2);
    chk("bp_last", last_deliv, 32'h7);
    word_ready = 1'b0;
    drive_word(32'h8);
    cyc(5);
    chk("bp_next_valid", word_valid, 1);
    chk("bp_next_word", word_out, 32'h8);
    word_ready = 1'b1;
    cyc(1);
    drive_null();
    cyc(5);
    chk("bp_next_ack", ncl_ack, 0);
    chk("bp_next_count", n_deliv, 3);

    // Skew: bits 0..4 of 0x15 arrive one per clock; upper bits already at rail0.
    word_ready = 1'b0;
    ncl_rail0  = 32'hFFFF_FFE0;
    ncl_rail1  = '0;
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) ncl_rail1[i] = 1'b1;
      else ncl_rail0[i] = 1'b1;
      cyc(1);
      chk($sformatf("skew_partial%0d", i), word_valid, 0);
    end
    cyc(2);
    chk("skew_wait", word_valid, 0);
    cyc(1);
    chk("skew_valid", word_valid, 1);
    chk("skew_word", word_out, 32'h15);
    chk("skew_err", err_illegal, 0);
    word_ready = 1'b1;
    cyc(1);
    drive_null();
    cyc(5);
    chk("skew_ack", ncl_ack, 0);

    // Illegal: bit 3 with both rails high for 4 clocks.
    ncl_rail0 = 32'h8;
    ncl_rail1 = 32'h8;
    cyc(4);
    chk("ill_err", err_illegal, 1);
    chk("ill_valid", word_valid, 0);
    chk("ill_ack", ncl_ack, 0);
    drive_null();
    cyc(4);
    send_word(32'h9);
    chk("ill_sticky", err_illegal, 1);
    chk("ill_good_last", last_deliv, 32'h9);
    chk("ill_good_ack", ncl_ack, 0);

`ifdef SEQ_CHECK_EN
    init_n = 1'b0;
    cyc(2);
    init_n = 1'b1;
    cyc(3);
    send_word(32'hFFFF_FFFE);
    chk("seq_first", seq_err, 0);
    send_word(32'hFFFF_FFFF);
    chk("seq_inc", seq_err, 0);
    send_word(32'h0);
    chk("seq_wrap", seq_err, 0);
    chk("seq_wrap_last", last_deliv, 32'h0);
    send_word(32'h2);
    chk("seq_gap", seq_err, 1);
`endif

    // Mid-word reset acts without a clock edge.
    word_ready = 1'b0;
    drive_word(32'h3);
    cyc(5);
    chk("mid_ack_before", ncl_ack, 1);
    #2 init_n = 1'b0;
    #1;
    chk("mid_ack", ncl_ack, 0);
    chk("mid_valid", word_valid, 0);
    chk("mid_word", word_out, 0);
    chk("mid_err", err_illegal, 0);
`ifdef SEQ_CHECK_EN
    chk("mid_seq", seq_err, 0);
`endif
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
